// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM sequencing fetch/decode/exec/mem/wb over one shared memory port
// Ports: clk; reset_n (synchronous, active-high); mem_rdata/mem_ack in; mem_req/mem_we/mem_addr_sel out;
//   inst/ALUOp/func plus datapath controls out; pc_write, out_valid and halted status out.
// Build option MEM_TIMEOUT_EN: bounded ack wait of ACK_TIMEOUT cycles ending in HALT, with a sticky timeout output.
module multicycle_sequencer #(
  parameter int WORD_SIZE   = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic [WORD_SIZE-1:0] inst,
  output logic                 RegDst,
  output logic                 Jump,
  output logic                 Branch,
  output logic                 MemRead,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [3:0]           ALUOp,
  output logic [5:0]           func,
  output logic                 pc_write,
  output logic                 out_valid,
`ifdef MEM_TIMEOUT_EN
  output logic                 timeout,
`endif
  output logic                 halted
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {C_ALUR, C_ALUI, C_LWD, C_SWD, C_BR, C_JMP, C_WWD, C_HLT} cls_t;
  state_t state, state_n;
  cls_t cls, cls_d;
  logic legal;
  logic [WORD_SIZE-1:0] ir;
  logic [3:0] op;
  logic [5:0] fn;
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
    $error("ACK_TIMEOUT must fit the 8-bit wait counter");
  end
  assign op = ir[15:12];
  assign fn = ir[5:0];
  assign cls_d = op <= 4'd3 ? C_BR : op <= 4'd6 ? C_ALUI : op == 4'd7 ? C_LWD : op == 4'd8 ? C_SWD :
                 op == 4'd9 ? C_JMP : fn < 6'd8 ? C_ALUR : fn == 6'd28 ? C_WWD : C_HLT;
  assign legal = op <= 4'd9 || (op == 4'd15 && (fn < 6'd8 || fn == 6'd28 || fn == 6'd29));
  // inst is forced to zero while resetting or halted so every output reads 0 there
  assign inst  = (reset_n || state == HALT) ? '0 : ir;
  assign ALUOp = inst[15:12];
  assign func  = inst[5:0];
`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic waiting, expire;
  assign waiting = state == FETCH || state == MEM;
  // an ack arriving in the expiry cycle completes the access instead of timing out
  assign expire = waiting && !mem_ack && wait_cnt == 8'(ACK_TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= waiting && !mem_ack ? wait_cnt + 8'd1 : '0;
      timeout  <= timeout || expire;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state <= FETCH;
      ir    <= '0;
      cls   <= C_ALUR;
    end else begin
      state <= state_n;
      if (state == FETCH && mem_ack) ir <= mem_rdata;
      if (state == DECODE) cls <= cls_d;
    end
  end
  always_comb begin
    state_n = state;
    {mem_req, mem_we, mem_addr_sel, Jump, Branch, MemRead, MemtoReg, MemWrite, RegWrite, pc_write, out_valid, halted} = '0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        state_n = mem_ack ? DECODE : FETCH;
      end
      DECODE: state_n = legal ? EXEC : HALT;
      EXEC: begin
        Branch    = cls == C_BR;
        Jump      = cls == C_JMP;
        out_valid = cls == C_WWD;
        pc_write  = cls inside {C_BR, C_JMP, C_WWD};
        state_n   = cls inside {C_ALUR, C_ALUI} ? WB : cls inside {C_LWD, C_SWD} ? MEM : cls == C_HLT ? HALT : FETCH;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = cls == C_SWD;
        MemWrite     = cls == C_SWD;
        MemRead      = cls == C_LWD;
        pc_write     = mem_ack && cls == C_SWD;
        state_n      = !mem_ack ? MEM : cls == C_LWD ? WB : FETCH;
      end
      WB: begin
        RegWrite = 1'b1;
        pc_write = 1'b1;
        MemtoReg = cls == C_LWD;
        state_n  = FETCH;
      end
      default: begin
        halted  = 1'b1;
        state_n = HALT;
      end
    endcase
    // ALU operand selects stay stable from EXEC until the result is consumed
    RegDst = (state inside {EXEC, WB}) && cls == C_ALUR;
    ALUSrc = (state inside {EXEC, MEM, WB}) && (cls inside {C_ALUI, C_LWD, C_SWD});
`ifdef MEM_TIMEOUT_EN
    if (expire) state_n = HALT;
`endif
    if (reset_n) begin
      {mem_req, mem_we, mem_addr_sel, RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, pc_write, out_valid, halted} = '0;
      state_n = FETCH;
    end
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the 16-bit datapath (RF, ALU, PC_control) over several clocks instead of one.
- Owns the instruction register and a single shared memory port; fetch and data access use that one port via a req/ack handshake.
- Drives the datapath's existing control inputs plus per-state write enables (ir/pc/reg) so each architectural update happens in exactly one cycle.

Parameters:
- WORD_SIZE, 16, datapath and memory word width.
- ACK_TIMEOUT, 255, max cycles waiting for mem_ack before entering HALT (only used when MEM_TIMEOUT_EN is defined).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-high (1 = reset) despite the suffix; sampled on rising clk.
- mem_rdata  input  WORD_SIZE  memory read data, valid in the cycle mem_ack=1.
- mem_ack  input  1  one-cycle completion pulse for the outstanding request.
- mem_req  output  1  memory request, held until the ack cycle.
- mem_we  output  1  1 = write (SWD), 0 = read.
- mem_addr_sel  output  1  0 = PC (fetch), 1 = ALU result (data).
- inst  output  WORD_SIZE  instruction register contents to the datapath.
- RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  output  1 each  datapath controls.
- ALUOp  output  4  equals inst[15:12].
- func  output  6  equals inst[5:0].
- pc_write  output  1  PC register loads next_PC this cycle.
- out_valid  output  1  one-cycle pulse when WWD's output_port value is valid.
- halted  output  1  FSM is in HALT.

Behaviour:
- Reset: state=FETCH, inst=0, and every output 0.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is free.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - On mem_ack: inst<=mem_rdata, go to DECODE.
  - mem_req drops the cycle after ack.
- DECODE:
  - One cycle. Registers the instruction class: ALU-R (op 15, func 0-7), ADI/ORI/LHI (op 4-6), LWD (7), SWD (8), BNE/BEQ/BGZ/BLZ (0-3), JMP (9), WWD (op 15, func 28), HLT (op 15, func 29).
  - Any other encoding is illegal and goes to HALT.
- EXEC:
  - ALUSrc=1 for I-types, LWD and SWD. RegDst=1 for ALU-R.
  - ALU-R and I-ALU go to WB.
  - LWD and SWD go to MEM.
  - Branch class: Branch=1, pc_write=1, go to FETCH. PC_control resolves taken/not taken.
  - JMP: Jump=1, pc_write=1, go to FETCH.
  - WWD: out_valid=1, pc_write=1, go to FETCH.
  - HLT: go to HALT, no pc_write.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=MemWrite=(SWD), MemRead=(LWD). ALU controls held from EXEC.
  - Wait for mem_ack.
  - On ack, LWD goes to WB; the read data is captured by the datapath path on that cycle.
  - On ack, SWD asserts pc_write=1 and goes to FETCH.
- WB:
  - RegWrite=1 and pc_write=1 for one cycle. MemtoReg=1 for LWD.
  - Go to FETCH.
- Retirement rule: exactly one pc_write pulse per retired instruction. RegWrite pulses at most once per instruction and never outside WB.
- Controls are 0 in any state where they are not listed.
- HALT: halted=1, all other outputs 0. Remains in HALT until reset.
- mem_ack while mem_req=0 is ignored.
- mem_ack in the same cycle as the req rise is accepted, giving zero-wait memory.
- Reset asserted in any state, including mid-handshake: next state FETCH, outputs 0; the pending ack is discarded.
- Reset has priority over mem_ack.
- Latency with zero-wait memory (FETCH counts as 1 cycle):
  - ALU ops: 4 cycles.
  - LWD: 5 cycles.
  - SWD: 4 cycles.
  - Branch, JMP, WWD: 3 cycles.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears when entering FETCH or MEM and increments each cycle without ack.
  - When the count reaches ACK_TIMEOUT, go to HALT and raise output port timeout (1 bit, sticky until reset).
  - An ack in the same cycle as expiry wins.
- Undefined: no counter, no timeout port; the FSM waits indefinitely.

Test Plan:
- Reset held 3 cycles, then released with zero-wait memory; fetch ADD (0xF000) -> mem_req in cycle 1, pc_write and RegWrite with RegDst=1 in cycle 4, mem_req again in cycle 5.
- LWD 0x7104, ack delayed 3 cycles in MEM -> MemRead=1 held through the wait; WB cycle has MemtoReg=1 and RegWrite=1; exactly one pc_write.
- SWD 0x8104 -> MEM with mem_we=1 and mem_addr_sel=1; on ack pc_write=1; RegWrite never asserted.
- BEQ 0x1003 and JMP 0x9010 -> Branch=1 (or Jump=1) with pc_write on cycle 3; no memory data request.
- WWD 0xF01C -> out_valid pulse in EXEC; then HLT 0xF01D -> halted=1 stays set, mem_ack pulses ignored, reset returns to FETCH.
- Reset asserted mid-FETCH with ack in the same cycle -> inst stays 0, state FETCH. With MEM_TIMEOUT_EN and ACK_TIMEOUT=4, no ack -> HALT and timeout=1 after 4 wait cycles.
